// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 32-bit column per cycle through a single
// GF(2^8) multiplier network, IDLE -> CALC x4 -> DONE handshake.
module inv_mix_columns_iter (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iValid,
  input  logic [127:0] iMixText,
  input  logic         iAbort,
  output logic         oReady,
  output logic         oValid,
  output logic [127:0] oInvText
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] text_q, text_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic [COL_W-1:0]   col_in_c;
  logic [COL_W-1:0]   col_out_c;
  logic [6:0]         col_lsb_c;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply one byte by 09/0b/0d/0e; sel: 0=09, 1=0b, 2=0d, 3=0e
  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] x,
                                             input logic [1:0] sel);
    logic [BYTE_W-1:0] x2, x4, x8, r;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      2'd0:    r = x8 ^ x;
      2'd1:    r = x8 ^ x2 ^ x;
      2'd2:    r = x8 ^ x4 ^ x;
      default: r = x8 ^ x4 ^ x2;
    endcase
    return r;
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] a);
    logic [BYTE_W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = gmul(a0, 2'd3) ^ gmul(a1, 2'd1) ^ gmul(a2, 2'd2) ^ gmul(a3, 2'd0);
    b1 = gmul(a0, 2'd0) ^ gmul(a1, 2'd3) ^ gmul(a2, 2'd1) ^ gmul(a3, 2'd2);
    b2 = gmul(a0, 2'd2) ^ gmul(a1, 2'd0) ^ gmul(a2, 2'd3) ^ gmul(a3, 2'd1);
    b3 = gmul(a0, 2'd1) ^ gmul(a1, 2'd2) ^ gmul(a2, 2'd0) ^ gmul(a3, 2'd3);
    return {b0, b1, b2, b3};
  endfunction

  // Single shared column network, selected by the column counter
  assign col_lsb_c = {cnt_q, 5'd0};
  assign col_in_c  = state_q[col_lsb_c +: COL_W];
  assign col_out_c = inv_mix_col(col_in_c);

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    text_d  = text_q;
    case (fsm_q)
      IDLE: begin
        if (iValid) begin
          state_d = iMixText;
          cnt_d   = '0;
          fsm_d   = CALC;
        end
      end
      CALC: begin
        if (iAbort) begin
          cnt_d = '0;
          fsm_d = IDLE;
        end else begin
          text_d[col_lsb_c +: COL_W] = col_out_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) fsm_d = DONE;
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    ready_d = (fsm_d == IDLE);
    valid_d = (fsm_d == DONE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      text_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      text_q  <= text_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign oReady   = ready_q;
  assign oValid   = valid_q;
  assign oInvText = text_q;

endmodule
